// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared data width, route-select encodings and word type
package stream_demux_pkg;
    localparam int DATA_W = 32;
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/stream_demux_fifo.sv
// stream_fifo: DEPTH-entry FIFO with occupancy, output data forced to 0 when empty
module stream_fifo
    import stream_demux_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  word_t                  i_data,
    output word_t                  o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    word_t         r_mem [DEPTH];
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = r_level == LW'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    assign o_data  = o_empty ? '0 : r_mem[r_rptr];

    // pointers wrap naturally since DEPTH is a power of two; level tracks push minus pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // storage needs no reset: reads are masked while empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end
endmodule

// File: rtl/stream_demux.sv
// stream_demux: routes an input stream to one of two buffered outputs by in_sel
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sel,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   a_valid,
    input  logic                   a_ready,
    output logic [DATA_W-1:0]      a_data,
    output logic                   b_valid,
    input  logic                   b_ready,
    output logic [DATA_W-1:0]      b_data,
    output logic [$clog2(DEPTH):0] a_level,
    output logic [$clog2(DEPTH):0] b_level
);
    logic w_a_full;
    logic w_b_full;
    logic w_a_empty;
    logic w_b_empty;
    logic w_push_a;
    logic w_push_b;

    assign in_ready = ~rst & ((in_sel == SEL_B) ? ~w_b_full : ~w_a_full);
    assign w_push_a = in_valid & in_ready & (in_sel == SEL_A);
    assign w_push_b = in_valid & in_ready & (in_sel == SEL_B);
    assign a_valid  = ~w_a_empty;
    assign b_valid  = ~w_b_empty;

    stream_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_a),
        .i_pop   (a_ready),
        .i_data  (in_data),
        .o_data  (a_data),
        .o_full  (w_a_full),
        .o_empty (w_a_empty),
        .o_level (a_level)
    );

    stream_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_b),
        .i_pop   (b_ready),
        .i_data  (in_data),
        .o_data  (b_data),
        .o_full  (w_b_full),
        .o_empty (w_b_empty),
        .o_level (b_level)
    );
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed self-checking bench for stream_demux
module tb_stream_demux;
    localparam int DEPTH = 2;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sel = 1'b0;
    logic [31:0]   in_data = '0;
    logic          a_valid;
    logic          a_ready = 1'b0;
    logic [31:0]   a_data;
    logic          b_valid;
    logic          b_ready = 1'b0;
    logic [31:0]   b_data;
    logic [LW-1:0] a_level;
    logic [LW-1:0] b_level;
    int            n_cmp = 0;
    int            n_err = 0;

    stream_demux #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .a_level  (a_level),
        .b_level  (b_level)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if ({a_valid, b_valid} !== 2'b00) begin n_err++; $display("FAIL rst_valid: got %b want 00", {a_valid, b_valid}); end
        n_cmp++; if ({a_level, b_level} !== '0) begin n_err++; $display("FAIL rst_level: got %0d/%0d want 0/0", a_level, b_level); end
        n_cmp++; if ({a_data, b_data} !== '0) begin n_err++; $display("FAIL rst_data: got %0d/%0d want 0/0", a_data, b_data); end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", in_ready); end
        a_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'd11;
        @(negedge clk); in_data = 32'd22;
        @(negedge clk); in_valid = 1'b0;
        n_cmp++; if (a_level !== LW'(2)) begin n_err++; $display("FAIL pre_rst_level: got %0d want 2", a_level); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid: got %b want 0", a_valid); end
        n_cmp++; if (a_level !== '0) begin n_err++; $display("FAIL async_rst_level: got %0d want 0", a_level); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL async_rst_ready: got %b want 0", in_ready); end
        n_cmp++; if (a_data !== '0) begin n_err++; $display("FAIL async_rst_data: got %0d want 0", a_data); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({a_valid, a_level} !== '0) begin n_err++; $display("FAIL after_rst_empty: got valid %b level %0d want 0/0", a_valid, a_level); end
    endtask

    task automatic test_routing;
        a_ready = 1'b1; b_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'd5;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL route_ready: got %b want 1", in_ready); end
        @(negedge clk);
        n_cmp++; if ({a_valid, a_data} !== {1'b1, 32'd5}) begin n_err++; $display("FAIL route_a: got %b/%0d want 1/5", a_valid, a_data); end
        n_cmp++; if (b_valid !== 1'b0) begin n_err++; $display("FAIL route_b_idle: got %b want 0", b_valid); end
        in_sel = 1'b1; in_data = 32'd4;
        @(negedge clk);
        n_cmp++; if ({b_valid, b_data} !== {1'b1, 32'd4}) begin n_err++; $display("FAIL route_b: got %b/%0d want 1/4", b_valid, b_data); end
        n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL route_a_drained: got %b want 0", a_valid); end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (b_valid !== 1'b0) begin n_err++; $display("FAIL route_b_drained: got %b want 0", b_valid); end
    endtask

    task automatic test_backpressure;
        a_ready = 1'b0; b_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'd13;
        @(negedge clk);
        n_cmp++; if (a_level !== LW'(1)) begin n_err++; $display("FAIL bp_level1: got %0d want 1", a_level); end
        in_data = 32'd66;
        @(negedge clk);
        n_cmp++; if (a_level !== LW'(2)) begin n_err++; $display("FAIL bp_level2: got %0d want 2", a_level); end
        in_data = 32'd749;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
        @(negedge clk);
        n_cmp++; if ({a_level, a_data} !== {LW'(2), 32'd13}) begin n_err++; $display("FAIL bp_hold: got %0d/%0d want 2/13", a_level, a_data); end
        in_sel = 1'b1; in_data = 32'd619;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_b_ready: got %b want 1", in_ready); end
        @(negedge clk);
        n_cmp++; if ({b_level, b_data} !== {LW'(1), 32'd619}) begin n_err++; $display("FAIL bp_b_push: got %0d/%0d want 1/619", b_level, b_data); end
        n_cmp++; if (a_level !== LW'(2)) begin n_err++; $display("FAIL bp_a_untouched: got %0d want 2", a_level); end
        in_sel = 1'b0; in_data = 32'd749; a_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_pop_ready: got %b want 0", in_ready); end
        @(negedge clk);
        n_cmp++; if ({a_level, a_data} !== {LW'(1), 32'd66}) begin n_err++; $display("FAIL full_pop_only: got %0d/%0d want 1/66", a_level, a_data); end
        in_valid = 1'b0; b_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({a_level, b_level} !== '0) begin n_err++; $display("FAIL bp_drain: got %0d/%0d want 0/0", a_level, b_level); end
    endtask

    task automatic test_simultaneous;
        a_ready = 1'b0; b_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'd100;
        @(negedge clk);
        n_cmp++; if ({a_level, a_data} !== {LW'(1), 32'd100}) begin n_err++; $display("FAIL sim_pre: got %0d/%0d want 1/100", a_level, a_data); end
        a_ready = 1'b1; in_data = 32'd786;
        @(negedge clk);
        n_cmp++; if ({a_level, a_data} !== {LW'(1), 32'd786}) begin n_err++; $display("FAIL sim_pushpop: got %0d/%0d want 1/786", a_level, a_data); end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_level !== '0) begin n_err++; $display("FAIL sim_drain: got %0d want 0", a_level); end
    endtask

    task automatic test_streaming;
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        int k = 0;
        int rcv = 0;
        int cyc = 0;
        bit exp_rdy;
        while ((k < 100 || qa.size() != 0 || qb.size() != 0) && cyc < 2000) begin
            in_valid = (k < 100);
            in_sel = k[0];
            in_data = 32'd1000 + 32'(k);
            a_ready = ($urandom_range(0, 9) < 7);
            b_ready = ($urandom_range(0, 9) < 7);
            #1;
            exp_rdy = (in_sel ? qb.size() : qa.size()) < DEPTH;
            if (in_valid) begin
                n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL stream_ready k=%0d: got %b want %b", k, in_ready, exp_rdy); end
            end
            n_cmp++; if (a_valid !== (qa.size() != 0)) begin n_err++; $display("FAIL stream_a_valid cyc=%0d: got %b want %b", cyc, a_valid, qa.size() != 0); end
            n_cmp++; if (b_valid !== (qb.size() != 0)) begin n_err++; $display("FAIL stream_b_valid cyc=%0d: got %b want %b", cyc, b_valid, qb.size() != 0); end
            if (qa.size() != 0) begin
                n_cmp++; if (a_data !== qa[0]) begin n_err++; $display("FAIL stream_a_data cyc=%0d: got %0d want %0d", cyc, a_data, qa[0]); end
            end
            if (qb.size() != 0) begin
                n_cmp++; if (b_data !== qb[0]) begin n_err++; $display("FAIL stream_b_data cyc=%0d: got %0d want %0d", cyc, b_data, qb[0]); end
            end
            @(posedge clk);
            if (qa.size() != 0 && a_ready) begin void'(qa.pop_front()); rcv++; end
            if (qb.size() != 0 && b_ready) begin void'(qb.pop_front()); rcv++; end
            if (in_valid && exp_rdy) begin
                if (in_sel) qb.push_back(in_data); else qa.push_back(in_data);
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_cmp++; if (rcv != 100) begin n_err++; $display("FAIL stream_count: got %0d want 100 (cycles %0d)", rcv, cyc); end
        #1;
        n_cmp++; if ({a_valid, b_valid} !== 2'b00) begin n_err++; $display("FAIL stream_empty: got %b want 00", {a_valid, b_valid}); end
    endtask

    task automatic test_wrap;
        b_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            in_data = 32'd65035 + 32'(i);
            @(negedge clk);
            n_cmp++; if ({b_level, b_data} !== {LW'(1), 32'd65035 + 32'(i)}) begin n_err++; $display("FAIL wrap_%0d: got %0d/%0d want 1/%0d", i, b_level, b_data, 65035 + i); end
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (b_level !== '0) begin n_err++; $display("FAIL wrap_drain: got %0d want 0", b_level); end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_simultaneous();
        test_streaming();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter: DEPTH, 2, entries per output buffer (power of two, >= 2).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  input word present.
REQ-005 Port: in_ready  output  1  input word accepted this cycle when high together with in_valid.
REQ-006 Port: in_sel  input  1  route select: 0 means output A, 1 means output B.
REQ-007 Port: in_data  input  32  input word.
REQ-008 Port: a_valid  output  1  output A word present.
REQ-009 Port: a_ready  input  1  sink A accepts the word.
REQ-010 Port: a_data  output  32  output A word.
REQ-011 Port: b_valid  output  1  output B word present.
REQ-012 Port: b_ready  input  1  sink B accepts the word.
REQ-013 Port: b_data  output  32  output B word.
REQ-014 Port: a_level  output  $clog2(DEPTH)+1  output A buffer occupancy.
REQ-015 Port: b_level  output  $clog2(DEPTH)+1  output B buffer occupancy.

Function
REQ-016 The block SHALL route each accepted input word to output A when in_sel=0 and to output B when in_sel=1. This is the inverse of the 2:1 select mux.
REQ-017 Input handshake: a transfer occurs when in_valid and in_ready are both high at a rising edge. in_sel and in_data are sampled at that edge only.
REQ-018 in_ready SHALL be high when the buffer chosen by in_sel holds fewer than DEPTH entries. It depends combinationally on in_sel and the occupancy registers only, never on a_ready or b_ready.
REQ-019 Output handshake: a pop occurs on an output when its valid and ready are both high at a rising edge.
REQ-020 x_valid SHALL be high exactly when x_level is nonzero. x_data SHALL show the oldest buffered word for that output, held stable while valid is high and ready is low.
REQ-021 Latency SHALL be 1 cycle. A word accepted at edge N is visible on the selected output after edge N, with no combinational path from in_data to a_data or b_data.
REQ-022 Order SHALL be preserved within each output. No ordering is defined between A and B.
REQ-023 Full throughput: with DEPTH>=2 and the selected sink always ready, one word SHALL be accepted every cycle.
REQ-024 Push and pop on the same output in the same cycle SHALL leave its level unchanged and advance its data correctly. This includes the case level=DEPTH-1.
REQ-025 When an output is full, a push and pop in the same cycle SHALL NOT occur, because in_ready is low by REQ-018. The pop alone proceeds.
REQ-026 A push to one output and a pop from the other output in the same cycle SHALL be independent.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH. The level arithmetic width SHALL be $clog2(DEPTH)+1 so that DEPTH itself is representable.
REQ-028 When in_valid is low, no state SHALL change on the input side, whatever in_sel shows.

Reset
REQ-029 While rst is high, both buffers SHALL empty immediately (asynchronously).
REQ-030 While rst is high, these outputs SHALL be 0: a_valid, b_valid, a_level, b_level, a_data, b_data.
REQ-031 While rst is high, in_ready SHALL be 0.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered words. The first edge after rst deasserts may accept input.

Structure
REQ-033 A shared package SHALL hold DATA_W=32 and the select encodings SEL_A=1'b0 and SEL_B=1'b1.
REQ-034 The per-output buffer SHALL be one sub-module, stream_fifo, instantiated twice. It has push/pop/full/empty/level and DEPTH as a parameter.

Verification
REQ-035 Reset check: assert rst mid-run with A holding 2 words -> a_valid=0, a_level=0 and in_ready=0 immediately; after release, A is empty.
REQ-036 Basic routing: push 5 with sel=0, then 4 with sel=1, both sinks ready -> a_data=5 one cycle after accept, b_data=4 one cycle after its accept.
REQ-037 Backpressure: a_ready=0, push 13, 66 and 749 with sel=0 -> first two accepted, in_ready=0 for 749 with a_level=2; a push to B with value 619 is still accepted that cycle.
REQ-038 Simultaneous push/pop: a_level=1, push 786 while popping -> a_level stays 1, next a_data=786.
REQ-039 Streaming: 100 consecutive words, alternating sel, random ready ~70% -> each output sequence matches the order-preserving model with no loss or duplication.
REQ-040 Wrap-around: 2*DEPTH+1 pushes and pops on B with values 65035 onward -> data exact across pointer wrap.
